// File: rtl/receiver_pkg.sv
// Shared defaults and types for the receive side of the parallel link.
// Imported by the interface, the FIFO and the receiver top.
package receiver_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/receiver_if.sv
// Link handshake from the remote transmitter plus the local read port.
// The receiver uses the slave view; the transmitter/reader side uses master.
interface receiver_if
    import receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] parallel_data_in;
    logic              parallel_valid_in;
    logic              parallel_ready_out;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              fifo_empty;

    modport master (
        output parallel_data_in,
        output parallel_valid_in,
        input  parallel_ready_out,
        output rd_en,
        input  data_out,
        input  fifo_empty
    );

    modport slave (
        input  parallel_data_in,
        input  parallel_valid_in,
        output parallel_ready_out,
        input  rd_en,
        output data_out,
        output fifo_empty
    );

endinterface

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered read data and a registered empty flag.
// Occupancy is held in a count one bit wider than the pointers.
module rx_sync_fifo
    import receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_rx,
    input  logic              rst_rx,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which words are valid.
    always_ff @(posedge clk_rx) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/receiver.sv
// Receive end of a four-phase parallel link: valid synchroniser, IDLE/ACK
// handshake FSM and a receive FIFO drained by the local reader.
module receiver
    import receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic       clk_rx,
    input  logic       rst_rx,
    receiver_if.slave  link
);

    logic      sync_meta;
    logic      sync_valid;
    logic      fifo_wr;
    logic      fifo_full;
    rx_state_e state;
    rx_state_e state_next;

    // Only valid crosses domains; data is held stable by the transmitter while valid is high.
    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            sync_meta  <= 1'b0;
            sync_valid <= 1'b0;
        end else begin
            sync_meta  <= link.parallel_valid_in;
            sync_valid <= sync_meta;
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst_rx) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sync_valid && !fifo_full) state_next = ACK;
            ACK:     if (!sync_valid)              state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Acknowledge is a direct decode of the state flop, so it is glitch-free toward the link.
    always_comb begin
        fifo_wr                 = 1'b0;
        link.parallel_ready_out = 1'b0;
        if (state == IDLE && sync_valid && !fifo_full) fifo_wr = 1'b1;
        if (state == ACK) link.parallel_ready_out = 1'b1;
    end

    rx_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_rx (clk_rx),
        .rst_rx (rst_rx),
        .wr_en  (fifo_wr),
        .din    (link.parallel_data_in),
        .rd_en  (link.rd_en),
        .dout   (link.data_out),
        .full   (fifo_full),
        .empty  (link.fifo_empty)
    );

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: reset, handshake latency, streaming, back-pressure,
// empty reads, simultaneous read/write and reset during an acknowledge.
module tb_receiver;

    logic clk_rx;
    logic rst_rx;

    receiver_if #(.DATA_W(16)) link ();

    receiver #(
        .DATA_W (16),
        .DEPTH  (16)
    ) dut (
        .clk_rx (clk_rx),
        .rst_rx (rst_rx),
        .link   (link)
    );

    int          n_checks;
    int          n_pass;
    int          n_reads;
    logic        auto_rd;
    logic [15:0] exp_q [$];

    initial begin
        clk_rx = 1'b0;
        forever #5 clk_rx = ~clk_rx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; any read that fires at this edge is scored against the queue.
    task automatic tick();
        logic        fire;
        logic [15:0] exp_word;
        fire = link.rd_en && !link.fifo_empty;
        @(posedge clk_rx);
        #1;
        if (fire) begin
            exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            n_reads++;
            check("rd_data", 32'(link.data_out), 32'(exp_word));
        end
        if (auto_rd) link.rd_en = !link.fifo_empty;
    endtask

    task automatic wait_ready(input logic level, input string tag);
        int n;
        n = 0;
        while (link.parallel_ready_out !== level && n < 60) begin
            tick();
            n++;
        end
        check(tag, 32'(link.parallel_ready_out), 32'(level));
    endtask

    task automatic send(input logic [15:0] w);
        link.parallel_data_in  = w;
        link.parallel_valid_in = 1'b1;
        exp_q.push_back(w);
        wait_ready(1'b1, "ack_rise");
        link.parallel_valid_in = 1'b0;
        wait_ready(1'b0, "ack_fall");
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;
        n_reads  = 0;
        auto_rd  = 1'b0;
        rst_rx   = 1'b1;
        link.parallel_data_in  = '0;
        link.parallel_valid_in = 1'b0;
        link.rd_en             = 1'b0;

        // Reset state
        tick();
        tick();
        rst_rx = 1'b0;
        check("rst_ready", 32'(link.parallel_ready_out), 32'd0);
        check("rst_empty", 32'(link.fifo_empty), 32'd1);
        check("rst_dout",  32'(link.data_out), 32'd0);

        // Latency: valid rises mid-cycle, response exactly at the third edge
        @(negedge clk_rx);
        link.parallel_data_in  = 16'hD00D;
        link.parallel_valid_in = 1'b1;
        exp_q.push_back(16'hD00D);
        tick();
        check("lat_e1_ready", 32'(link.parallel_ready_out), 32'd0);
        check("lat_e1_empty", 32'(link.fifo_empty), 32'd1);
        tick();
        check("lat_e2_ready", 32'(link.parallel_ready_out), 32'd0);
        check("lat_e2_empty", 32'(link.fifo_empty), 32'd1);
        tick();
        check("lat_e3_ready", 32'(link.parallel_ready_out), 32'd1);
        check("lat_e3_empty", 32'(link.fifo_empty), 32'd0);
        link.parallel_valid_in = 1'b0;
        wait_ready(1'b0, "lat_ack_fall");
        link.rd_en = 1'b1;
        tick();
        link.rd_en = 1'b0;
        check("lat_drained", 32'(link.fifo_empty), 32'd1);

        // Streaming: 40 handshakes with the reader following fifo_empty
        n_reads = 0;
        auto_rd = 1'b1;
        link.rd_en = !link.fifo_empty;
        for (int i = 0; i < 40; i++) send(16'hAAAA + 16'(i));
        n = 0;
        while (!link.fifo_empty && n < 20) begin
            tick();
            n++;
        end
        tick();
        auto_rd = 1'b0;
        link.rd_en = 1'b0;
        check("stream_reads", 32'(n_reads), 32'd40);
        check("stream_queue", 32'(exp_q.size()), 32'd0);
        check("stream_empty", 32'(link.fifo_empty), 32'd1);

        // Back-pressure: 16 words fill the FIFO, word 17 waits for a free slot
        for (int i = 0; i < 16; i++) send(16'hB000 + 16'(i));
        check("full_not_empty", 32'(link.fifo_empty), 32'd0);
        link.parallel_data_in  = 16'hB010;
        link.parallel_valid_in = 1'b1;
        exp_q.push_back(16'hB010);
        for (int i = 0; i < 10; i++) tick();
        check("bp_ready_low", 32'(link.parallel_ready_out), 32'd0);
        link.rd_en = 1'b1;
        tick();
        link.rd_en = 1'b0;
        wait_ready(1'b1, "bp_ack_rise");
        link.parallel_valid_in = 1'b0;
        wait_ready(1'b0, "bp_ack_fall");
        n_reads = 0;
        link.rd_en = 1'b1;
        n = 0;
        while (!link.fifo_empty && n < 30) begin
            tick();
            n++;
        end
        link.rd_en = 1'b0;
        check("bp_drain_reads", 32'(n_reads), 32'd16);
        check("bp_queue", 32'(exp_q.size()), 32'd0);

        // Reads while empty are ignored
        link.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("emptyrd_dout",  32'(link.data_out), 32'h0000B010);
            check("emptyrd_empty", 32'(link.fifo_empty), 32'd1);
        end
        link.rd_en = 1'b0;

        // Simultaneous read and write with one word held
        send(16'hC001);
        link.parallel_data_in  = 16'hC002;
        link.parallel_valid_in = 1'b1;
        exp_q.push_back(16'hC002);
        tick();
        tick();
        link.rd_en = 1'b1;
        tick();
        link.rd_en = 1'b0;
        check("rw_ready",     32'(link.parallel_ready_out), 32'd1);
        check("rw_not_empty", 32'(link.fifo_empty), 32'd0);
        link.parallel_valid_in = 1'b0;
        wait_ready(1'b0, "rw_ack_fall");
        link.rd_en = 1'b1;
        tick();
        link.rd_en = 1'b0;
        check("rw_one_left", 32'(link.fifo_empty), 32'd1);

        // Reset while acknowledging, with valid still high
        link.parallel_data_in  = 16'hE0E0;
        link.parallel_valid_in = 1'b1;
        tick();
        tick();
        tick();
        check("rstack_ready_pre", 32'(link.parallel_ready_out), 32'd1);
        rst_rx = 1'b1;
        tick();
        rst_rx = 1'b0;
        check("rstack_ready", 32'(link.parallel_ready_out), 32'd0);
        check("rstack_empty", 32'(link.fifo_empty), 32'd1);
        check("rstack_dout",  32'(link.data_out), 32'd0);
        exp_q.push_back(16'hE0E0);
        wait_ready(1'b1, "rstack_recapture");
        link.parallel_valid_in = 1'b0;
        wait_ready(1'b0, "rstack_ack_fall");
        link.rd_en = 1'b1;
        tick();
        tick();
        link.rd_en = 1'b0;
        check("rstack_once",  32'(link.fifo_empty), 32'd1);
        check("rstack_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of link and output data.
REQ-002 SHALL have parameter DEPTH, default 16, receive FIFO depth in words (power of two).
REQ-003 SHALL have port clk_rx  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_rx  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port parallel_data_in  input  DATA_W  link data from the remote transmitter, asynchronous to clk_rx.
REQ-006 SHALL have port parallel_valid_in  input  1  link request from the remote transmitter, asynchronous to clk_rx.
REQ-007 SHALL have port parallel_ready_out  output  1  link acknowledge to the transmitter, registered.
REQ-008 SHALL have port rd_en  input  1  user read request.
REQ-009 SHALL have port data_out  output  DATA_W  FIFO read data, registered.
REQ-010 SHALL have port fifo_empty  output  1  high when the FIFO holds no words.

Function
REQ-011 SHALL synchronise parallel_valid_in through a two-flop synchroniser (sync_valid = second flop); parallel_data_in is not synchronised, because the transmitter holds it stable while valid is high.
REQ-012 SHALL implement a four-phase handshake FSM with states IDLE and ACK.
REQ-013 In IDLE, when sync_valid=1 and the FIFO is not full, the receiver SHALL write parallel_data_in into the FIFO, set parallel_ready_out=1 and go to ACK, all at the same edge.
REQ-014 In IDLE with the FIFO full, the receiver SHALL NOT capture the word and SHALL keep parallel_ready_out=0 (back-pressure) until a slot frees.
REQ-015 In ACK, when sync_valid=0, the receiver SHALL clear parallel_ready_out and return to IDLE; while sync_valid=1 it stays in ACK and performs no further writes.
REQ-016 Each valid assertion SHALL produce exactly one FIFO write.
REQ-017 Latency: with valid_in stable before edge E1, the write, ready_out rise and fifo_empty fall SHALL all occur at edge E3.
REQ-018 The FIFO SHALL be synchronous-read: rd_en=1 with fifo_empty=0 at edge N places the oldest word on data_out after edge N; data_out holds its value otherwise.
REQ-019 A read while empty SHALL be ignored; data_out and the pointers are unchanged.
REQ-020 A simultaneous read and write SHALL both take effect and leave the occupancy unchanged; when empty, only the write occurs.
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a count of width log2(DEPTH)+1; full when count==DEPTH.
REQ-022 fifo_empty SHALL be registered/derived from count==0 and SHALL update at the same edge as the write or read that changes it.
REQ-023 Words SHALL be delivered in arrival order, bit-exact.

Reset
REQ-024 On rst_rx=1 at a clock edge: FSM=IDLE, parallel_ready_out=0, synchroniser flops=0, pointers and count=0, fifo_empty=1, data_out=0.
REQ-025 Reset mid-handshake SHALL abandon the in-flight word's acknowledge; after reset, a still-high valid_in is treated as a new request.
REQ-026 FIFO storage contents need not be reset.

Structure
REQ-027 A shared package SHALL hold DATA_W default, the FSM state enum typedef (IDLE, ACK) and a clog2-based address width constant.
REQ-028 The FIFO SHALL be a sub-module named rx_sync_fifo (wr_en, din, rd_en, dout, full, empty); the synchroniser and FSM SHALL stay in receiver.

Verification
REQ-029 After reset, drive 40 handshakes with data 0xAAAA..0xAAD1 while rd_en=!fifo_empty: all 40 SHALL be read in order with zero mismatches.
REQ-030 With rd_en=0, send 17 words: after 16 writes fifo_empty=0 and ready_out SHALL stay 0 for word 17; after one read, word 17 SHALL be acknowledged and stored.
REQ-031 With an empty FIFO, drive rd_en=1 for 5 cycles: data_out SHALL be unchanged and fifo_empty SHALL stay 1.
REQ-032 With the FIFO holding one word, apply rd_en at the edge where a new word is written: count SHALL stay 1 and data_out SHALL show the older word.
REQ-033 Assert rst_rx while in ACK with valid_in high: ready_out=0 and fifo_empty=1 SHALL hold after the edge; the word SHALL then be re-captured once.
REQ-034 Check the latency: valid_in rises mid-cycle; ready_out and the fifo_empty fall SHALL appear exactly at the third following edge.
